// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add 8x8 multiplier (product mod 256) that steers an
// external combinational ALU one micro-operation per cycle.
module alu_mul_seq (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] OpA,
  input  logic [7:0] OpB,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic [3:0] AluOp,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [2:0] AluIm,
  input  logic [7:0] AluOut,
  input  logic       AluBranch
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LSH = 4'd1;
  localparam logic [3:0] OP_RSH = 4'd2;
  localparam logic [3:0] OP_BNZ = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ADDS = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [7:0] result_q, result_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_im_q, alu_im_d;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = OpA;
          mplier_d = OpB;
          acc_d    = 8'd0;
          state_d  = S_TEST;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_TEST: begin
        if (!AluBranch) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else if (mplier_q[0]) begin
          state_d  = S_ADDS;
        end else begin
          state_d  = S_SHL;
        end
      end
      S_ADDS: begin
        acc_d   = AluOut;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = AluOut;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = AluOut;
        state_d  = S_TEST;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops present the
  // drive for the state that is current after the edge.
  always_comb begin
    alu_op_d = OP_ADD;
    alu_a_d  = 8'd0;
    alu_b_d  = 8'd0;
    alu_im_d = 3'd0;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    case (state_d)
      S_IDLE: busy_d = 1'b0;
      S_TEST: begin
        alu_op_d = OP_BNZ;
        alu_a_d  = mplier_d;
      end
      S_ADDS: begin
        alu_op_d = OP_ADD;
        alu_a_d  = acc_d;
        alu_b_d  = mcand_d;
      end
      S_SHL: begin
        alu_op_d = OP_LSH;
        alu_a_d  = mcand_d;
        alu_im_d = 3'd1;
      end
      S_SHR: begin
        alu_op_d = OP_RSH;
        alu_a_d  = mplier_d;
        alu_im_d = 3'd1;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 8'd0;
      mcand_q  <= 8'd0;
      mplier_q <= 8'd0;
      result_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_op_q <= OP_ADD;
      alu_a_q  <= 8'd0;
      alu_b_q  <= 8'd0;
      alu_im_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_im_q <= alu_im_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign AluOp  = alu_op_q;
  assign AluA   = alu_a_q;
  assign AluB   = alu_b_q;
  assign AluIm  = alu_im_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU, directed vector table, hand-written
// corner sequences and a randomised check against plain-arithmetic rules.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LSH = 4'd1;
  localparam logic [3:0] OP_RSH = 4'd2;
  localparam logic [3:0] OP_BNZ = 4'd3;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [7:0] OpA, OpB;
  logic       Busy, Done;
  logic [7:0] Result;
  logic [3:0] AluOp;
  logic [7:0] AluA, AluB;
  logic [2:0] AluIm;
  logic [7:0] AluOut;
  logic       AluBranch;

  int errors = 0;
  int checks = 0;

  alu_mul_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Result(Result),
    .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluIm(AluIm),
    .AluOut(AluOut), .AluBranch(AluBranch)
  );

  always #5 Clk = ~Clk;

  // Behavioural model of the external ALU.
  always_comb begin
    AluOut    = 8'd0;
    AluBranch = 1'b0;
    case (AluOp)
      OP_ADD: AluOut = AluA + AluB;
      OP_LSH: AluOut = AluA << AluIm;
      OP_RSH: AluOut = AluA >> AluIm;
      OP_BNZ: AluBranch = (AluA != 8'd0);
      default: AluOut = 8'd0;
    endcase
  end

  function automatic int ref_product(input logic [7:0] a, input logic [7:0] b);
    return (int'(a) * int'(b)) % 256;
  endfunction

  function automatic int ref_latency(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return 2 + 3 * n + $countones(b);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  logic [3:0] ops[$];
  int         got_lat;
  bit         busy_ok;

  // Launch one operation from IDLE and watch it until Done (bounded).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    bit got_done = 1'b0;
    @(negedge Clk);
    Start = 1'b1; OpA = a; OpB = b;
    @(posedge Clk);
    ops.delete();
    got_lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        got_done = 1'b1;
        got_lat  = c;
      end else begin
        ops.push_back(AluOp);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] seq_exp[12];
  int         lat1, lat2, dones;
  logic [7:0] ra, rb;

  initial begin
    vecs[0] = '{8'd3,   8'd5,   8'd15,  13};
    vecs[1] = '{8'h55,  8'h00,  8'h00,  2};
    vecs[2] = '{8'h00,  8'hFF,  8'h00,  34};
    vecs[3] = '{8'h10,  8'h20,  8'h00,  21};
    vecs[4] = '{8'hFF,  8'hFF,  8'h01,  34};
    vecs[5] = '{8'h0F,  8'h11,  8'hFF,  19};
    seq_exp = '{OP_BNZ, OP_ADD, OP_LSH, OP_RSH, OP_BNZ, OP_LSH,
                OP_RSH, OP_BNZ, OP_ADD, OP_LSH, OP_RSH, OP_BNZ};

    Reset = 1'b1; Start = 1'b0; OpA = 8'd0; OpB = 8'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy",   int'(Busy),   0);
    check("rst_done",   int'(Done),   0);
    check("rst_result", int'(Result), 0);
    check("rst_aluop",  int'(AluOp),  int'(OP_ADD));
    check("rst_alua",   int'(AluA),   0);

    // 3x5 micro-op sequence
    run_op(8'd3, 8'd5);
    check("seq_len", ops.size(), 12);
    for (int i = 0; i < 12 && i < ops.size(); i++)
      check($sformatf("seq_op%0d", i), int'(ops[i]), int'(seq_exp[i]));

    // zero multiplier issues only the branch test
    run_op(8'h55, 8'h00);
    check("zero_b_ops", ops.size(), 1);
    if (ops.size() > 0) check("zero_b_op0", int'(ops[0]), int'(OP_BNZ));

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_result", i), int'(Result), int'(vecs[i].res));
      check($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), int'(busy_ok), 1);
    end

    // Start held high and operands changed while busy
    @(negedge Clk);
    Start = 1'b1; OpA = 8'd6; OpB = 8'd3;
    @(posedge Clk);
    lat1 = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 60 && lat1 == 0; c++) begin
      @(negedge Clk);
      if (c == 2) begin OpA = 8'd9; OpB = 8'd7; end
      if (!Busy) busy_ok = 1'b0;
      if (Done) lat1 = c;
    end
    check("hold_lat1", lat1, ref_latency(8'd3));
    check("hold_res1", int'(Result), 18);
    check("hold_busy1", int'(busy_ok), 1);
    @(negedge Clk);
    check("hold_idle_busy", int'(Busy), 0);
    check("hold_idle_res", int'(Result), 18);
    @(posedge Clk);
    lat2 = 0;
    for (int c = 1; c <= 60 && lat2 == 0; c++) begin
      @(negedge Clk);
      if (c == 1) begin Start = 1'b0; OpA = 8'hAA; OpB = 8'h01; end
      if (Done) lat2 = c;
    end
    check("hold_lat2", lat2, ref_latency(8'd7));
    check("hold_res2", int'(Result), 63);

    // Reset during the SHL cycle of 7x9
    @(negedge Clk);
    Start = 1'b1; OpA = 8'd7; OpB = 8'd9;
    @(posedge Clk);
    repeat (3) begin @(negedge Clk); Start = 1'b0; end
    check("rst_mid_op_is_lsh", int'(AluOp), int'(OP_LSH));
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_mid_busy",   int'(Busy),   0);
    check("rst_mid_result", int'(Result), 0);
    check("rst_mid_done",   int'(Done),   0);
    dones = 0;
    repeat (40) begin @(negedge Clk); if (Done) dones++; end
    check("rst_mid_no_done", dones, 0);
    run_op(8'd7, 8'd9);
    check("after_rst_res", int'(Result), 63);
    check("after_rst_lat", got_lat, ref_latency(8'd9));

    // randomised operands against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb);
      check($sformatf("rand%0d_res_%0d_x_%0d", i, ra, rb), int'(Result), ref_product(ra, rb));
      check($sformatf("rand%0d_lat_b%0d", i, rb), got_lat, ref_latency(rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
